// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs between datapath and controller
interface pipe_hazard_ctrl_if #(parameter int RA_W = 5, parameter int CNT_W = 16);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_uses_rt;
  logic [RA_W-1:0] id_rwd;
  logic            id_is_load;
  logic            ex_br_taken;
  logic            mem_busy;
  logic            pc_stall;
  logic            ifid_stall;
  logic            ifid_flush;
  logic            idex_bubble;
  logic            pipe_freeze;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;
  modport master(
    output id_valid, id_rs, id_rt, id_uses_rt, id_rwd, id_is_load, ex_br_taken, mem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel, stall_cycles
  );
  modport slave(
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rwd, id_is_load, ex_br_taken, mem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush/freeze and EX forwarding control for a 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, FREEZE} state_t;
  state_t r_state, w_state_nx;
  logic             r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [RA_W-1:0]  r_ex_rd, r_ex_rs, r_ex_rt, r_mem_rd, r_wb_rd;
  logic             r_ex_ld, r_ex_urt, r_mem_ld;
  logic             w_flush, w_lu, w_stall, w_kill;
  logic [1:0]       w_fwd_a, w_fwd_b;
  // a pending flush only exists after a frozen cycle, so it is applied on leaving FREEZE
  always_comb begin
    w_state_nx = bus.mem_busy ? FREEZE : RUN;
    w_flush    = !bus.mem_busy && (bus.ex_br_taken || (r_state == FREEZE && r_pend));
    w_lu       = !bus.mem_busy && !w_flush && bus.id_valid && r_ex_ld && (|r_ex_rd) &&
                 (r_ex_rd == bus.id_rs || (bus.id_uses_rt && r_ex_rd == bus.id_rt));
    w_stall    = bus.mem_busy || w_lu;
    w_kill     = w_flush || w_lu || !bus.id_valid;
    w_fwd_a    = ((|r_mem_rd) && !r_mem_ld && r_mem_rd == r_ex_rs) ? 2'b01 :
                 ((|r_wb_rd) && r_wb_rd == r_ex_rs) ? 2'b10 : 2'b00;
    w_fwd_b    = !r_ex_urt ? 2'b00 :
                 ((|r_mem_rd) && !r_mem_ld && r_mem_rd == r_ex_rt) ? 2'b01 :
                 ((|r_wb_rd) && r_wb_rd == r_ex_rt) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_pend   <= 1'b0;
      r_cnt    <= '0;
      r_ex_rd  <= '0;
      r_ex_rs  <= '0;
      r_ex_rt  <= '0;
      r_ex_ld  <= 1'b0;
      r_ex_urt <= 1'b0;
      r_mem_rd <= '0;
      r_mem_ld <= 1'b0;
      r_wb_rd  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pend  <= bus.mem_busy ? (r_pend || bus.ex_br_taken) : 1'b0;
      if (w_stall && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      if (!bus.mem_busy) begin
        r_wb_rd  <= r_mem_rd;
        r_mem_rd <= r_ex_rd;
        r_mem_ld <= r_ex_ld;
        r_ex_rd  <= w_kill ? '0 : bus.id_rwd;
        r_ex_rs  <= w_kill ? '0 : bus.id_rs;
        r_ex_rt  <= w_kill ? '0 : bus.id_rt;
        r_ex_ld  <= !w_kill && bus.id_is_load;
        r_ex_urt <= !w_kill && bus.id_uses_rt;
      end
    end
  end
  assign bus.pc_stall     = w_stall;
  assign bus.ifid_stall   = w_stall;
  assign bus.ifid_flush   = w_flush;
  assign bus.idex_bubble  = w_flush || w_lu;
  assign bus.pipe_freeze  = bus.mem_busy;
  assign bus.fwd_a_sel    = w_fwd_a;
  assign bus.fwd_b_sel    = w_fwd_b;
  assign bus.stall_cycles = r_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed controls, forwarding selects and stall counts
module tb_pipe_hazard_ctrl;
  localparam int RA_W = 5, CNT_W = 4;
  logic clk = 1'b0, rst = 1'b1;
  int n_tests = 0, n_fail = 0;
  pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus();
  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] ctl();
    return {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble, bus.pipe_freeze};
  endfunction
  task automatic set_id(input logic v, input logic [4:0] rs, rt, input logic urt,
                        input logic [4:0] rd, input logic ld);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_uses_rt = urt; bus.id_rwd = rd; bus.id_is_load = ld;
  endtask
  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0);
    bus.ex_br_taken = 0; bus.mem_busy = 0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic flush_pipe();
    idle(); tick(); tick(); tick();
  endtask
  initial begin
    bus.id_valid = $urandom; bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
    bus.id_uses_rt = $urandom; bus.id_rwd = 5'($urandom); bus.id_is_load = $urandom;
    bus.ex_br_taken = $urandom; bus.mem_busy = $urandom;
    tick(); tick();
    rst = 0; idle(); #1;
    chk("rst_ctl", 16'(ctl()), 16'h0);
    chk("rst_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'h0);
    chk("rst_cnt", 16'(bus.stall_cycles), 16'h0);
    // load-use: LDW r3 then ADD r4,r3,r5
    set_id(1, 1, 0, 0, 3, 1); #1;
    chk("ldw_ctl", 16'(ctl()), 16'h0);
    tick();
    set_id(1, 3, 5, 1, 4, 0); #1;
    chk("lu_ctl", 16'(ctl()), 16'b11010);
    tick();
    chk("lu_clear", 16'(ctl()), 16'h0);
    tick(); idle(); #1;
    chk("lu_fwd_a", 16'(bus.fwd_a_sel), 16'h2);
    chk("lu_fwd_b", 16'(bus.fwd_b_sel), 16'h0);
    chk("lu_cnt", 16'(bus.stall_cycles), 16'h1);
    // back-to-back ADD r2 / SUB r6,r2,r2
    flush_pipe();
    set_id(1, 7, 8, 1, 2, 0); tick();
    set_id(1, 2, 2, 1, 6, 0); #1;
    chk("b2b_nostall", 16'(ctl()), 16'h0);
    tick(); idle(); #1;
    chk("b2b_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'b0101);
    // one NOP gap
    flush_pipe();
    set_id(1, 7, 8, 1, 2, 0); tick();
    idle(); tick();
    set_id(1, 2, 2, 1, 6, 0); tick(); idle(); #1;
    chk("gap_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'b1010);
    // r0 never forwards
    flush_pipe();
    set_id(1, 7, 8, 1, 0, 0); tick();
    set_id(1, 0, 0, 1, 6, 0); tick(); idle(); #1;
    chk("r0_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'b0000);
    // MEM beats WB when both write r2
    flush_pipe();
    set_id(1, 7, 8, 1, 2, 0); tick();
    set_id(1, 9, 8, 1, 2, 0); tick();
    set_id(1, 2, 2, 1, 6, 0); tick(); idle(); #1;
    chk("prio_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'b0101);
    // branch taken overrides load-use
    flush_pipe();
    set_id(1, 1, 0, 0, 3, 1); tick();
    set_id(1, 3, 5, 1, 4, 0); bus.ex_br_taken = 1; #1;
    chk("br_lu_ctl", 16'(ctl()), 16'b00110);
    tick(); idle(); #1;
    chk("br_lu_cnt", 16'(bus.stall_cycles), 16'h1);
    // freeze 3 cycles with a branch in the 2nd
    flush_pipe();
    set_id(1, 7, 8, 1, 2, 0); tick();
    set_id(1, 2, 2, 1, 6, 0); tick();
    idle(); bus.mem_busy = 1; #1;
    chk("frz1_ctl", 16'(ctl()), 16'b11001);
    chk("frz1_fwd", 16'(bus.fwd_a_sel), 16'h1);
    tick(); bus.ex_br_taken = 1; #1;
    chk("frz2_ctl", 16'(ctl()), 16'b11001);
    tick(); bus.ex_br_taken = 0; #1;
    chk("frz3_ctl", 16'(ctl()), 16'b11001);
    chk("frz3_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'b0101);
    tick(); bus.mem_busy = 0; #1;
    chk("frz_flush", 16'(ctl()), 16'b00110);
    chk("frz_held", 16'(bus.fwd_a_sel), 16'h1);
    tick(); #1;
    chk("post_flush", 16'(ctl()), 16'h0);
    chk("post_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'b0000);
    chk("frz_cnt", 16'(bus.stall_cycles), 16'h4);
    // saturate, then reset mid-freeze with a flush pending
    bus.mem_busy = 1; bus.ex_br_taken = 1; tick();
    bus.ex_br_taken = 0;
    for (int i = 0; i < 13; i++) tick();
    chk("sat_cnt", 16'(bus.stall_cycles), 16'hF);
    rst = 1; tick();
    rst = 0; idle(); #1;
    chk("rst2_ctl", 16'(ctl()), 16'h0);
    chk("rst2_cnt", 16'(bus.stall_cycles), 16'h0);
    chk("rst2_fwd", {12'h0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
